// File: rtl/dmem_responder.sv
// Memory-side responder for the data memory bus: synchronous RAM, programmable wait states,
// one-cycle ready pulse, tri-state read return. Optional even parity via DMEM_PARITY_EN.
module dmem_responder #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dmem_req,
  input  logic                  dmem_write,
  input  logic [ADDR_WIDTH-1:0] dmem_addr,
  inout  wire  [DATA_WIDTH-1:0] dmem_data,
  output logic                  dmem_ready,
  output logic                  dmem_busy
`ifdef DMEM_PARITY_EN
  ,
  output logic                  dmem_parity_err
`endif
);

  if (WAIT_STATES > 15) begin : g_bad_cfg
    $fatal(1, "dmem_responder: WAIT_STATES must be in 0..15");
  end

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StWait  = 3'd1;
  localparam logic [2:0] StWrite = 3'd2;
  localparam logic [2:0] StRead  = 3'd3;
  localparam logic [2:0] StDrive = 3'd4;

  localparam logic [3:0] LastCnt = 4'(WAIT_STATES - 1);

  logic [2:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  busy_q, ready_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (dmem_req) begin
          cnt_d = 4'd0;
          if (WAIT_STATES == 0) begin
            state_d = dmem_write ? StWrite : StRead;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (cnt_q == LastCnt) begin
          cnt_d   = 4'd0;
          state_d = write_q ? StWrite : StRead;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StWrite: state_d = StIdle;
      StRead:  state_d = StDrive;
      StDrive: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Busy and ready are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d != StIdle);
      ready_q <= (state_d == StWrite) || (state_d == StDrive);
    end
  end

  // Datapath; array and output latch updates are suppressed by rst so an access can be aborted.
  always_ff @(posedge clk) begin
    if (state_q == StIdle && dmem_req) begin
      addr_q  <= dmem_addr;
      write_q <= dmem_write;
      if (dmem_write) begin
        wdata_q <= dmem_data;
      end
    end
    if (!rst && state_q == StWrite) begin
      mem[addr_q] <= wdata_q;
    end
    if (!rst && state_q == StRead) begin
      rdata_q <= mem[addr_q];
    end
  end

`ifdef DMEM_PARITY_EN
  logic mem_par [2**ADDR_WIDTH];
  logic parity_err_q;

  always_ff @(posedge clk) begin
    if (!rst && state_q == StWrite) begin
      mem_par[addr_q] <= ^wdata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      parity_err_q <= 1'b0;
    end else if (state_q == StRead && ((^mem[addr_q]) != mem_par[addr_q])) begin
      parity_err_q <= 1'b1;
    end
  end

  assign dmem_parity_err = parity_err_q;
`endif

  // The live write strobe gates the driver so the initiator can never fight the read return.
  assign dmem_data  = (state_q == StDrive && !dmem_write) ? rdata_q : {DATA_WIDTH{1'bz}};
  assign dmem_ready = ready_q;
  assign dmem_busy  = busy_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (WAIT_STATES=1 and 0), transaction-level reference
// model, per-cycle compare process, directed literal checks and randomized traffic.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       req  [2];
  logic       wr   [2];
  logic [7:0] addr [2];
  logic       drv  [2];
  logic [7:0] wd   [2];
  logic       rdy  [2];
  logic       bsy  [2];
  logic [7:0] busv [2];
  wire  [7:0] bus0;
  wire  [7:0] bus1;
`ifdef DMEM_PARITY_EN
  logic       perr [2];
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit chk_on   = 1'b0;

  // Reference model: one outstanding transaction per instance, timed from its acceptance edge.
  bit [7:0] mm      [2][256];
  bit       m_valid [2];
  bit       m_wr    [2];
  bit [7:0] m_addr  [2];
  bit [7:0] m_data  [2];
  int       m_start [2];
  int       m_end   [2];

  always #5 clk = ~clk;

  dmem_responder #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (8),
    .WAIT_STATES(1)
  ) u_dut0 (
    .clk       (clk),
    .rst       (rst),
    .dmem_req  (req[0]),
    .dmem_write(wr[0]),
    .dmem_addr (addr[0]),
    .dmem_data (bus0),
    .dmem_ready(rdy[0]),
    .dmem_busy (bsy[0])
`ifdef DMEM_PARITY_EN
    ,
    .dmem_parity_err(perr[0])
`endif
  );

  dmem_responder #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (8),
    .WAIT_STATES(0)
  ) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .dmem_req  (req[1]),
    .dmem_write(wr[1]),
    .dmem_addr (addr[1]),
    .dmem_data (bus1),
    .dmem_ready(rdy[1]),
    .dmem_busy (bsy[1])
`ifdef DMEM_PARITY_EN
    ,
    .dmem_parity_err(perr[1])
`endif
  );

  assign bus0    = drv[0] ? wd[0] : 8'hzz;
  assign bus1    = drv[1] ? wd[1] : 8'hzz;
  assign busv[0] = bus0;
  assign busv[1] = bus1;

  function automatic int ws_of(input int i);
    return (i == 0) ? 1 : 0;
  endfunction

  // An undriven bus reads as Z on a 4-state simulator and as 0 on a 2-state one.
  function automatic bit released(input logic [7:0] v);
    return (v === 8'hzz) || (v === 8'h00);
  endfunction

  always @(posedge clk) begin
    int k;
    k   = cyc + 1;
    cyc = k;
    if (rst) chk_on = 1'b1;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_valid[i] = 1'b0;
      end else begin
        if (m_valid[i] && m_wr[i] && k == m_end[i] + 1) mm[i][m_addr[i]] = m_data[i];
        if (!(m_valid[i] && (k - 1) >= m_start[i] && (k - 1) <= m_end[i]) && req[i]) begin
          m_valid[i] = 1'b1;
          m_start[i] = k;
          m_wr[i]    = wr[i];
          m_addr[i]  = addr[i];
          m_end[i]   = k + ws_of(i) + (wr[i] ? 0 : 1);
          m_data[i]  = wr[i] ? wd[i] : mm[i][addr[i]];
        end
      end
    end
  end

  always @(negedge clk) begin
    bit eb, er, ed;
    if (chk_on) begin
      for (int i = 0; i < 2; i++) begin
        eb = m_valid[i] && cyc >= m_start[i] && cyc <= m_end[i];
        er = m_valid[i] && cyc == m_end[i];
        ed = er && !m_wr[i] && !wr[i];
        checks++;
        if (bsy[i] !== eb) begin
          failures++;
          $display("FAIL busy inst=%0d cyc=%0d got=%b exp=%b", i, cyc, bsy[i], eb);
        end
        checks++;
        if (rdy[i] !== er) begin
          failures++;
          $display("FAIL ready inst=%0d cyc=%0d got=%b exp=%b", i, cyc, rdy[i], er);
        end
        checks++;
        if (drv[i]) begin
          if (busv[i] !== wd[i]) begin
            failures++;
            $display("FAIL bus_tb inst=%0d cyc=%0d got=%h exp=%h", i, cyc, busv[i], wd[i]);
          end
        end else if (ed) begin
          if (busv[i] !== m_data[i]) begin
            failures++;
            $display("FAIL bus_rd inst=%0d cyc=%0d got=%h exp=%h", i, cyc, busv[i], m_data[i]);
          end
        end else if (!released(busv[i])) begin
          failures++;
          $display("FAIL bus_z inst=%0d cyc=%0d got=%h exp=released", i, cyc, busv[i]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic chk_rel(input string name, input logic [7:0] got);
    checks++;
    if (!released(got)) begin
      failures++;
      $display("FAIL %s got=%h exp=released", name, got);
    end
  endtask

  // Called and returns at posedge+1. Latency counts the request cycle as 0.
  // With poke set, the initiator keeps req=1/write=1 (bus not driven) until ready is seen.
  task automatic access(input int i, input bit w, input bit [7:0] a, input bit [7:0] d,
                        input bit poke, output int lat, output logic [7:0] rd);
    int k0;
    bit seen;
    req[i] = 1'b1; wr[i] = w; addr[i] = a; wd[i] = d; drv[i] = w;
    @(posedge clk); #1;
    k0 = cyc;
    if (poke) begin
      req[i] = 1'b1; wr[i] = 1'b1; drv[i] = 1'b0; addr[i] = a ^ 8'h01;
    end else begin
      req[i] = 1'b0; wr[i] = 1'b0; drv[i] = 1'b0;
    end
    lat  = -1;
    rd   = 8'h00;
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      if (rdy[i] === 1'b1) begin
        seen = 1'b1;
        lat  = cyc - k0 + 1;
        rd   = busv[i];
      end
    end
    @(posedge clk); #1;
    req[i] = 1'b0; wr[i] = 1'b0; drv[i] = 1'b0;
  endtask

  task automatic count_ready(input int i, input int n, output int cnt);
    cnt = 0;
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      if (rdy[i] === 1'b1) cnt++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, nr;
    logic [7:0] rd;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; wr[i] = 1'b0; addr[i] = 8'h00; drv[i] = 1'b0; wd[i] = 8'h00;
      m_valid[i] = 1'b0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy0", {31'd0, bsy[0]}, 32'd0);
    chk("reset_ready0", {31'd0, rdy[0]}, 32'd0);
    chk("reset_busy1", {31'd0, bsy[1]}, 32'd0);
    chk("reset_ready1", {31'd0, rdy[1]}, 32'd0);
    chk_rel("reset_bus0", busv[0]);
    chk_rel("reset_bus1", busv[1]);
    rst = 1'b0;

    fork
      begin
        int l0;
        logic [7:0] r0;
        for (int a = 0; a < 256; a++) access(0, 1'b1, a[7:0], 8'($urandom_range(1, 255)), 1'b0, l0, r0);
      end
      begin
        int l1;
        logic [7:0] r1;
        for (int a = 0; a < 256; a++) access(1, 1'b1, a[7:0], 8'($urandom_range(1, 255)), 1'b0, l1, r1);
      end
    join

    access(0, 1'b1, 8'h10, 8'hA5, 1'b0, lat, rd);
    chk("ws1_write_latency", lat, 32'd2);
    access(0, 1'b0, 8'h10, 8'h00, 1'b0, lat, rd);
    chk("ws1_read_latency", lat, 32'd3);
    chk("ws1_read_data", {24'd0, rd}, 32'hA5);

    access(1, 1'b1, 8'h3C, 8'hFF, 1'b0, lat, rd);
    chk("ws0_write_latency", lat, 32'd1);
    access(1, 1'b0, 8'h3C, 8'h00, 1'b0, lat, rd);
    chk("ws0_read_latency", lat, 32'd2);
    chk("ws0_read_data", {24'd0, rd}, 32'hFF);

    // Abort a write to 0x20 with reset while it is in WAIT.
    access(0, 1'b1, 8'h20, 8'h00, 1'b0, lat, rd);
    req[0] = 1'b1; wr[0] = 1'b1; addr[0] = 8'h20; wd[0] = 8'h55; drv[0] = 1'b1;
    @(posedge clk); #1;
    req[0] = 1'b0; wr[0] = 1'b0; drv[0] = 1'b0;
    rst = 1'b1;
    count_ready(0, 1, nr);
    @(posedge clk); #1;
    rst = 1'b0;
    begin
      int nr2;
      count_ready(0, 4, nr2);
      nr += nr2;
    end
    chk("abort_no_ready", nr, 32'd0);
    @(posedge clk); #1;
    access(0, 1'b0, 8'h20, 8'h00, 1'b0, lat, rd);
    chk("abort_read_latency", lat, 32'd3);
    chk("abort_read_data", {24'd0, rd}, 32'h00);

    // Requests while busy are ignored; write=1 during DRIVE keeps the driver off.
    access(0, 1'b0, 8'h10, 8'h00, 1'b1, lat, rd);
    chk("contend_latency", lat, 32'd3);
    chk_rel("contend_bus_released", rd);
    count_ready(0, 3, nr);
    chk("busy_no_second_ready", nr, 32'd0);
    @(posedge clk); #1;
    access(0, 1'b0, 8'h10, 8'h00, 1'b0, lat, rd);
    chk("busy_mem_intact", {24'd0, rd}, 32'hA5);

    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < 2; i++) begin
        req[i]  = ($urandom_range(0, 2) == 0);
        wr[i]   = 1'($urandom_range(0, 1));
        addr[i] = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 7)) : 8'($urandom);
        wd[i]   = 8'($urandom);
        drv[i]  = wr[i] && (req[i] || ($urandom_range(0, 1) == 1));
      end
      rst = ($urandom_range(0, 149) == 0);
      @(posedge clk); #1;
    end
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; wr[i] = 1'b0; drv[i] = 1'b0;
    end
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;

`ifdef DMEM_PARITY_EN
    access(0, 1'b1, 8'h10, 8'hA5, 1'b0, lat, rd);
    chk("parity_clean", {31'd0, perr[0]}, 32'd0);
    u_dut0.mem[8'h10] = u_dut0.mem[8'h10] ^ 8'h01;
    mm[0][8'h10] = 8'hA4;
    access(0, 1'b0, 8'h10, 8'h00, 1'b0, lat, rd);
    chk("parity_read_latency", lat, 32'd3);
    chk("parity_read_data", {24'd0, rd}, 32'hA4);
    chk("parity_err_set", {31'd0, perr[0]}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("parity_err_sticky", {31'd0, perr[0]}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("parity_err_cleared", {31'd0, perr[0]}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side end of the data memory bus; the MCU-side data memory interface is the initiator.
- Holds a synchronous RAM array behind the shared address, write and tri-state data port.
- Answers each request with a programmable number of wait states and a one-cycle ready pulse.
- Releases the data bus to high impedance whenever it is not returning read data.

Parameters:
- DATA_WIDTH, 8: width of the data bus and of each memory word.
- ADDR_WIDTH, 8: address width; the array depth is 2**ADDR_WIDTH words.
- WAIT_STATES, 1: cycles between request acceptance and completion; legal range 0..15.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- dmem_req  input  1  access strobe from the initiator; sampled only in IDLE.
- dmem_write  input  1  1 = write access, 0 = read access; sampled with dmem_req.
- dmem_addr  input  ADDR_WIDTH  word address; sampled with dmem_req.
- dmem_data  inout  DATA_WIDTH  shared data bus.
- dmem_ready  output  1  one-cycle completion pulse.
- dmem_busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state becomes IDLE and the wait counter becomes 0.
  - dmem_ready=0, dmem_busy=0, data bus driver disabled (dmem_data is all Z).
  - Array contents are not cleared.
  - Reset asserted mid-access aborts the access: no array write, no bus drive, no ready pulse.
- Request capture:
  - In IDLE with dmem_req=1, the addr, write and data (when writing) values are latched at the edge.
  - After latching, the block ignores input changes until it returns to IDLE.
- States:
  - IDLE: dmem_req=1 moves to WAIT when WAIT_STATES>0. When WAIT_STATES=0 it moves straight to WRITE or READ.
  - WAIT: the counter counts 0..WAIT_STATES-1, then moves to WRITE (latched write=1) or READ.
  - WRITE: the latched data is stored at the latched address at this edge. dmem_ready=1 for this cycle. Next state is IDLE.
  - READ: the array word is registered into the output latch at this edge. Next state is DRIVE.
  - DRIVE: dmem_data carries the output latch for exactly one cycle and dmem_ready=1. Next state is IDLE.
- Bus driving:
  - dmem_data is driven only in DRIVE and only while dmem_write=0. In every other case it is Z.
  - If dmem_write=1 during DRIVE, the driver stays off (contention guard) but ready still pulses.
- Latency, counted from the dmem_req sampling edge to the ready cycle:
  - Write: WAIT_STATES+1 cycles.
  - Read: WAIT_STATES+2 cycles.
- dmem_busy equals (state != IDLE) and is registered with the state.
- Back-to-back accesses: a dmem_req=1 in the cycle of the ready pulse is not accepted. The earliest acceptance is the cycle after ready.
- Read-after-write to the same address returns the newly written value.
- Address wrap: the address is exactly ADDR_WIDTH bits, so out-of-range accesses cannot occur.
- WAIT_STATES values outside 0..15 are a configuration error; simulation shall stop with $fatal.

Optional Feature:
- Macro: DMEM_PARITY_EN.
- Defined:
  - Each word is stored with an even-parity bit computed on write.
  - On READ the stored parity is recomputed and compared.
  - A mismatch sets the sticky output dmem_parity_err (1 bit, added after dmem_busy); only rst clears it.
  - The data is still returned and the ready timing is unchanged.
- Not defined: the parity port and parity storage do not exist.

Test Plan:
- Reset: rst=1 for 2 cycles -> dmem_ready=0, dmem_busy=0, dmem_data all Z, state IDLE.
- Write then read, WAIT_STATES=1:
  - Write addr 0x10, data 0xA5 -> ready pulses 2 cycles after the request edge.
  - Read 0x10 -> 0xA5 on the bus and ready both appear 3 cycles after the request edge; bus is Z before and after.
- WAIT_STATES=0:
  - Write 0xFF to 0x3C -> ready on the next cycle.
  - Read 0x3C -> data 0xFF with ready 2 cycles after the request.
- Reset mid-access:
  - Write 0x55 to 0x20 is requested; rst=1 during WAIT.
  - Subsequent read of 0x20 returns the prior value 0x00 (preloaded), and no ready pulse occurs during the aborted access.
- Busy and contention:
  - Pulse dmem_req while busy -> ignored, no second ready.
  - Hold dmem_write=1 during DRIVE -> dmem_data stays Z and ready still pulses.
- DMEM_PARITY_EN:
  - Force-flip bit 0 of the stored word at 0x10, then read -> dmem_parity_err=1 and it stays high until rst.
